// File: rtl/svm_request_arbiter_if.sv
// Requester/response bus for svm_request_arbiter.
// slave: arbiter side (accepts feature vectors, produces tagged results).
// master: the side that drives requests and consumes results.
interface svm_request_arbiter_if #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned NUM_FEATURES = 16,
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned ID_W         = 2
);
  logic [NUM_REQ-1:0]                         req_valid;
  logic [NUM_REQ-1:0]                         req_ready;
  logic [NUM_REQ*NUM_FEATURES*DATA_WIDTH-1:0] req_features;
  logic                                       resp_valid;
  logic                                       resp_ready;
  logic [ID_W-1:0]                            resp_id;
  logic [DATA_WIDTH-1:0]                      resp_decision;
  logic                                       resp_prediction;
  logic                                       resp_error;
  logic [15:0]                                resp_latency;

  modport slave (
    input  req_valid, req_features, resp_ready,
    output req_ready, resp_valid, resp_id, resp_decision, resp_prediction, resp_error,
           resp_latency
  );

  modport master (
    output req_valid, req_features, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_decision, resp_prediction, resp_error,
           resp_latency
  );
endinterface

// File: rtl/svm_request_arbiter.sv
// Round-robin arbiter sharing one linear_svm core among NUM_REQ feature sources.
// Latches the winner's vector, pulses core_input_valid, waits for the result and
// returns it tagged with requester ID and measured core latency.
// Optional watchdog: define SVM_WATCHDOG_EN to abort a WAIT after TIMEOUT_CYCLES.
module svm_request_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned NUM_FEATURES   = 16,
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned ID_W           = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                               clk,
  input  logic                               rst,
  svm_request_arbiter_if.slave               host,
  output logic                               core_input_valid,
  output logic [NUM_FEATURES*DATA_WIDTH-1:0] core_features_flat,
  input  logic                               core_output_valid,
  input  logic [DATA_WIDTH-1:0]              core_decision,
  input  logic                               core_prediction,
  output logic                               core_soft_rst,
  output logic                               busy
);

  localparam int VEC_W = int'(NUM_FEATURES * DATA_WIDTH);

`ifdef SVM_WATCHDOG_EN
  localparam bit WDOG_EN = 1'b1;
`else
  localparam bit WDOG_EN = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e          state;
  logic [ID_W-1:0] last_grant;
  logic [15:0]     lat_cnt;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0] grant_id;
  logic [ID_W-1:0] idx;
  logic            found;
  logic            accept;
  logic            timeout_hit;

  // Round-robin search starting just after the last winner; only offered in IDLE.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = '0;
    for (int i = 1; i <= int'(NUM_REQ); i++) begin
      idx = ID_W'((int'(last_grant) + i) % int'(NUM_REQ));
      if (!found && host.req_valid[idx]) begin
        found    = 1'b1;
        grant_id = idx;
      end
    end
    // Gated by rst so every output reads 0 while reset is held.
    if (found && (state == StIdle) && !rst) begin
      grant[grant_id] = 1'b1;
    end
  end

  assign host.req_ready = grant;
  assign accept         = |grant;
  assign busy           = (state != StIdle);
  // Constant-false when the watchdog is compiled out, so WAIT never expires.
  assign timeout_hit    = WDOG_EN && (lat_cnt == 16'(TIMEOUT_CYCLES));

  // Transaction sequencer: accept, issue, wait for the core, hold the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                <= StIdle;
      last_grant           <= ID_W'(NUM_REQ - 1);
      lat_cnt              <= '0;
      core_input_valid     <= 1'b0;
      core_features_flat   <= '0;
      core_soft_rst        <= 1'b0;
      host.resp_valid      <= 1'b0;
      host.resp_id         <= '0;
      host.resp_decision   <= '0;
      host.resp_prediction <= 1'b0;
      host.resp_error      <= 1'b0;
      host.resp_latency    <= '0;
    end else begin
      core_input_valid <= 1'b0;
      core_soft_rst    <= 1'b0;
      unique case (state)
        StIdle: begin
          if (accept) begin
            core_features_flat <= host.req_features[int'(grant_id) * VEC_W +: VEC_W];
            host.resp_id       <= grant_id;
            last_grant         <= grant_id;
            core_input_valid   <= 1'b1;
            state              <= StIssue;
          end
        end
        StIssue: begin
          lat_cnt <= 16'd1;
          state   <= StWait;
        end
        StWait: begin
          // A real result beats a simultaneous timeout.
          if (core_output_valid) begin
            host.resp_decision   <= core_decision;
            host.resp_prediction <= core_prediction;
            host.resp_latency    <= lat_cnt;
            host.resp_error      <= 1'b0;
            host.resp_valid      <= 1'b1;
            state                <= StResp;
          end else if (timeout_hit) begin
            core_soft_rst        <= 1'b1;
            host.resp_decision   <= '0;
            host.resp_prediction <= 1'b0;
            host.resp_latency    <= 16'(TIMEOUT_CYCLES);
            host.resp_error      <= 1'b1;
            host.resp_valid      <= 1'b1;
            state                <= StResp;
          end else if (lat_cnt != 16'hFFFF) begin
            lat_cnt <= lat_cnt + 16'd1;
          end
        end
        StResp: begin
          if (host.resp_ready) begin
            host.resp_valid <= 1'b0;
            state           <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_svm_request_arbiter.sv
// Directed bench for svm_request_arbiter with a behavioural core
// (decision = sum of features, result 5 cycles after input_valid).
module tb_svm_request_arbiter;

  localparam int NR = 4;
  localparam int NF = 16;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic core_input_valid;
  logic [NF*DW-1:0] core_features_flat;
  logic core_output_valid;
  logic [DW-1:0] core_decision;
  logic core_prediction;
  logic core_soft_rst;
  logic busy;

  logic core_mute = 1'b0;
  logic spur_valid = 1'b0;
  logic [15:0] spur_dec = 16'h0000;
  logic mdl_valid;
  logic [15:0] mdl_dec;
  logic [15:0] pend_sum;
  logic [2:0] pend;

  int n_chk = 0;
  int n_pass = 0;

  svm_request_arbiter_if #(.NUM_REQ(NR), .NUM_FEATURES(NF), .DATA_WIDTH(DW), .ID_W(2)) host_if();

  svm_request_arbiter #(
    .NUM_REQ(NR), .NUM_FEATURES(NF), .DATA_WIDTH(DW), .ID_W(2), .TIMEOUT_CYCLES(20)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .host               (host_if),
    .core_input_valid   (core_input_valid),
    .core_features_flat (core_features_flat),
    .core_output_valid  (core_output_valid),
    .core_decision      (core_decision),
    .core_prediction    (core_prediction),
    .core_soft_rst      (core_soft_rst),
    .busy               (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] vec_sum(input logic [NF*DW-1:0] v);
    logic [15:0] s;
    s = '0;
    for (int f = 0; f < NF; f++) s = s + v[f*DW +: DW];
    return s;
  endfunction

  // Behavioural core with fixed latency of 5 cycles.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pend      <= '0;
      pend_sum  <= '0;
      mdl_valid <= 1'b0;
      mdl_dec   <= '0;
    end else begin
      mdl_valid <= 1'b0;
      if (core_input_valid && !core_mute) begin
        pend     <= 3'd4;
        pend_sum <= vec_sum(core_features_flat);
      end else if (pend != 0) begin
        pend <= pend - 3'd1;
        if (pend == 3'd1) begin
          mdl_valid <= 1'b1;
          mdl_dec   <= pend_sum;
        end
      end
    end
  end

  assign core_output_valid = mdl_valid | spur_valid;
  assign core_decision     = spur_valid ? spur_dec : mdl_dec;
  assign core_prediction   = ~core_decision[15];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic set_fill(input logic [3:0][15:0] fill);
    for (int r = 0; r < NR; r++)
      for (int f = 0; f < NF; f++)
        host_if.req_features[(r*NF + f)*DW +: DW] = fill[r];
  endtask

  // Offer a request at a negedge, check the grant, then check the start pulse.
  task automatic do_accept(input string nm, input logic [3:0] valid,
                           input logic [3:0][15:0] fill, input logic [3:0] exp_ready);
    @(negedge clk);
    set_fill(fill);
    host_if.req_valid = valid;
    #1;
    check({nm, "_ready"}, 64'(host_if.req_ready), 64'(exp_ready));
    @(negedge clk);
    host_if.req_valid = '0;
    check({nm, "_start"}, 64'(core_input_valid), 64'd1);
  endtask

  task automatic wait_resp(input string nm);
    @(negedge clk);
    check({nm, "_start_pulse"}, 64'(core_input_valid), 64'd0);
    for (int i = 0; i < 40 && !host_if.resp_valid; i++) @(negedge clk);
    check({nm, "_resp_valid"}, 64'(host_if.resp_valid), 64'd1);
  endtask

  task automatic handshake(input string nm);
    host_if.resp_ready = 1'b1;
    @(negedge clk);
    host_if.resp_ready = 1'b0;
    check({nm, "_busy_clr"}, 64'(busy), 64'd0);
    check({nm, "_resp_clr"}, 64'(host_if.resp_valid), 64'd0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [3:0]       valid;
    logic [3:0][15:0] fill;
    logic [3:0]       exp_ready;
    logic [1:0]       exp_id;
    logic [15:0]      exp_dec;
    logic             exp_pred;
  } vec_t;

  vec_t vecs [6];
  int bad;
  int bad_rdy;
  int pulses;
  int n_seen;
  int idle_cnt;
  int resp_cnt;
  logic [1:0] ids [8];

  initial begin
    #1ms;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Round-robin pointer starts at 3, so each row's winner follows from the previous row.
    vecs[0] = '{4'b0100, {16'h0200, 16'h0100, 16'h0300, 16'h0400}, 4'b0100, 2'd2, 16'h1000, 1'b1};
    vecs[1] = '{4'b1111, {16'h0040, 16'h0030, 16'h0020, 16'h0010}, 4'b1000, 2'd3, 16'h0400, 1'b1};
    vecs[2] = '{4'b0110, {16'h0000, 16'h0001, 16'hFFF0, 16'h0000}, 4'b0010, 2'd1, 16'hFF00, 1'b0};
    vecs[3] = '{4'b0011, {16'h0000, 16'h0000, 16'h0100, 16'h0800}, 4'b0001, 2'd0, 16'h8000, 1'b0};
    vecs[4] = '{4'b1001, {16'h0005, 16'h0000, 16'h0000, 16'h0100}, 4'b1000, 2'd3, 16'h0050, 1'b1};
    vecs[5] = '{4'b1000, {16'h0000, 16'h0000, 16'h0000, 16'h0000}, 4'b1000, 2'd3, 16'h0000, 1'b1};

    host_if.req_valid    = 4'hF;
    host_if.req_features = '0;
    host_if.resp_ready   = 1'b0;

    // Reset state, with requests present to show req_ready is held low.
    @(negedge clk);
    check("reset_outputs",
          64'({host_if.req_ready, host_if.resp_valid, busy, core_input_valid, core_soft_rst,
               host_if.resp_id, host_if.resp_error, host_if.resp_prediction}), 64'd0);
    check("reset_data", 64'({host_if.resp_decision, host_if.resp_latency}), 64'd0);
    check("reset_features", 64'(|core_features_flat), 64'd0);
    host_if.req_valid = '0;
    rst = 1'b0;

    // Table of single transactions.
    for (int i = 0; i < 6; i++) begin
      string nm;
      nm = $sformatf("row%0d", i);
      do_accept(nm, vecs[i].valid, vecs[i].fill, vecs[i].exp_ready);
      wait_resp(nm);
      check({nm, "_id"}, 64'(host_if.resp_id), 64'(vecs[i].exp_id));
      check({nm, "_dec"}, 64'(host_if.resp_decision), 64'(vecs[i].exp_dec));
      check({nm, "_pred"}, 64'(host_if.resp_prediction), 64'(vecs[i].exp_pred));
      check({nm, "_lat"}, 64'(host_if.resp_latency), 64'd5);
      check({nm, "_err"}, 64'(host_if.resp_error), 64'd0);
      handshake(nm);
    end

    // Backpressure: result held for 10 cycles while every requester asks.
    do_accept("bp", 4'b0001, {16'h0, 16'h0, 16'h0, 16'h0123}, 4'b0001);
    wait_resp("bp");
    check("bp_dec", 64'(host_if.resp_decision), 64'h1230);
    bad = 0;
    bad_rdy = 0;
    host_if.req_valid = 4'hF;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (!host_if.resp_valid || host_if.resp_id != 2'd0 || host_if.resp_decision != 16'h1230 ||
          host_if.resp_latency != 16'd5 || !busy) bad++;
      if (host_if.req_ready != 4'b0000) bad_rdy++;
    end
    check("bp_stable", 64'(bad), 64'd0);
    check("bp_no_ready", 64'(bad_rdy), 64'd0);
    handshake("bp");
    host_if.req_valid = '0;

    // Spurious core strobe while idle.
    @(negedge clk);
    spur_dec = 16'h7777;
    spur_valid = 1'b1;
    @(negedge clk);
    spur_valid = 1'b0;
    @(negedge clk);
    check("spur_idle_valid", 64'({host_if.resp_valid, busy}), 64'd0);
    check("spur_idle_dec", 64'(host_if.resp_decision), 64'h1230);
    check("spur_idle_lat", 64'(host_if.resp_latency), 64'd5);

    // Spurious core strobe while holding a result.
    do_accept("sp", 4'b0010, {16'h0, 16'h0, 16'h0002, 16'h0}, 4'b0010);
    wait_resp("sp");
    spur_valid = 1'b1;
    @(negedge clk);
    spur_valid = 1'b0;
    @(negedge clk);
    check("spur_resp_valid", 64'(host_if.resp_valid), 64'd1);
    check("spur_resp_dec", 64'(host_if.resp_decision), 64'h0020);
    check("spur_resp_id", 64'(host_if.resp_id), 64'd1);
    check("spur_resp_lat", 64'(host_if.resp_latency), 64'd5);
    handshake("sp");

    // Reset two cycles after the core start aborts the transaction.
    do_accept("rw", 4'b0100, {16'h0, 16'h0009, 16'h0, 16'h0010}, 4'b0100);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    host_if.req_valid = 4'hF;
    #1;
    check("rw_reset_outputs",
          64'({host_if.req_ready, host_if.resp_valid, busy, core_input_valid, core_soft_rst,
               host_if.resp_id, host_if.resp_error, host_if.resp_prediction}), 64'd0);
    check("rw_reset_data", 64'({host_if.resp_decision, host_if.resp_latency}), 64'd0);
    check("rw_reset_features", 64'(|core_features_flat), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rw_first_ready", 64'(host_if.req_ready), 64'b0001);
    @(negedge clk);
    host_if.req_valid = '0;
    check("rw_start", 64'(core_input_valid), 64'd1);
    wait_resp("rw");
    check("rw_id", 64'(host_if.resp_id), 64'd0);
    check("rw_dec", 64'(host_if.resp_decision), 64'h0100);
    handshake("rw");

    // Core that never answers.
    core_mute = 1'b1;
    do_accept("wd", 4'b0010, {16'h0, 16'h0, 16'h0044, 16'h0}, 4'b0010);
`ifdef SVM_WATCHDOG_EN
    pulses = 0;
    for (int i = 0; i < 60 && !host_if.resp_valid; i++) begin
      @(negedge clk);
      if (core_soft_rst) pulses++;
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (core_soft_rst) pulses++;
    end
    check("wd_resp_valid", 64'(host_if.resp_valid), 64'd1);
    check("wd_soft_rst_pulses", 64'(pulses), 64'd1);
    check("wd_error", 64'(host_if.resp_error), 64'd1);
    check("wd_dec", 64'(host_if.resp_decision), 64'd0);
    check("wd_pred", 64'(host_if.resp_prediction), 64'd0);
    check("wd_lat", 64'(host_if.resp_latency), 64'd20);
    check("wd_id", 64'(host_if.resp_id), 64'd1);
    handshake("wd");
`else
    idle_cnt = 0;
    resp_cnt = 0;
    pulses = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!busy) idle_cnt++;
      if (host_if.resp_valid) resp_cnt++;
      if (core_soft_rst) pulses++;
    end
    check("nowd_busy_held", 64'(idle_cnt), 64'd0);
    check("nowd_no_resp", 64'(resp_cnt), 64'd0);
    check("nowd_no_soft_rst", 64'(pulses), 64'd0);
`endif
    core_mute = 1'b0;
    apply_reset();

    // Fairness: all requesters asserted continuously, consumer always ready.
    n_seen = 0;
    bad = 0;
    @(negedge clk);
    host_if.req_valid = 4'hF;
    host_if.resp_ready = 1'b1;
    for (int c = 0; c < 300 && n_seen < 8; c++) begin
      @(negedge clk);
      if (busy && host_if.req_ready != 4'b0000) bad++;
      if (host_if.resp_valid) begin
        ids[n_seen] = host_if.resp_id;
        n_seen++;
      end
    end
    host_if.req_valid = '0;
    host_if.resp_ready = 1'b0;
    check("fair_count", 64'(n_seen), 64'd8);
    for (int k = 0; k < 8; k++) begin
      if (k < n_seen) check($sformatf("fair_id%0d", k), 64'(ids[k]), 64'(k % 4));
    end
    check("fair_no_ready_busy", 64'(bad), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/svm_request_arbiter.md
Name: svm_request_arbiter

Overview:
Shares one linear_svm inference core among NUM_REQ independent feature sources, such as per-symbol market-data feature extractors. Grants requesters round-robin and latches the winner's feature vector. Issues a single-cycle input_valid to the core, waits for output_valid, then returns the decision tagged with requester ID and measured core latency. Weights and bias stay owned by the AXI register block; this block only sequences features and results.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
NUM_FEATURES, 16, feature elements per vector
DATA_WIDTH, 16, Q8.8 element width
ID_W, 2, requester ID width, clog2(NUM_REQ)
TIMEOUT_CYCLES, 255, watchdog limit in WAIT (used only with SVM_WATCHDOG_EN)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
req_valid  in  NUM_REQ  per-requester vector valid
req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
req_features  in  NUM_REQ*NUM_FEATURES*DATA_WIDTH  requester r occupies slice r
core_input_valid  out  1  single-cycle start to linear_svm
core_features_flat  out  NUM_FEATURES*DATA_WIDTH  latched winner vector
core_output_valid  in  1  core result strobe
core_decision  in  DATA_WIDTH  core decision value (signed Q8.8)
core_prediction  in  1  core class bit
core_soft_rst  out  1  one-cycle core reset pulse (watchdog)
resp_valid  out  1  result available
resp_ready  in  1  consumer accept
resp_id  out  ID_W  requester index of result
resp_decision  out  DATA_WIDTH  latched decision
resp_prediction  out  1  latched prediction
resp_error  out  1  result produced by timeout
resp_latency  out  16  cycles from issue to core_output_valid
busy  out  1  state != IDLE

Behaviour:
- Reset is asynchronous, active-high. All outputs reset to 0. State = IDLE. Feature latch = 0. Round-robin pointer last_grant = NUM_REQ-1, so requester 0 has first priority.
- The FSM has four states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready is combinational: one-hot to the first requester with req_valid=1, searching from last_grant+1 upward with wrap-around modulo NUM_REQ. All zero if no req_valid.
  - A transfer occurs when req_valid[r] & req_ready[r].
  - On transfer: latch req_features slice r into core_features_flat, latch resp_id=r, set last_grant=r, go to ISSUE.
- ISSUE:
  - core_input_valid=1 for exactly this cycle.
  - Latency counter loads 1. Go to WAIT.
  - Latency from accept to core start = 1 cycle.
- WAIT:
  - Latency counter increments each cycle, saturating at 0xFFFF.
  - On core_output_valid: latch core_decision and core_prediction, set resp_latency = counter, resp_error=0, go to RESP.
- RESP:
  - resp_valid=1, with resp_* held stable until resp_ready=1.
  - On resp_valid & resp_ready: resp_valid drops next cycle and state returns to IDLE.
  - The earliest next accept is the cycle after handshake; no same-cycle re-grant.
- core_output_valid in IDLE, ISSUE or RESP is ignored. No state, latch or counter changes.
- core_features_flat stays stable from ISSUE until the next accept.
- Requester inputs may change freely while not granted. Only the accept cycle is sampled.
- Requester r, once granted, is lowest priority next round. With all NUM_REQ requesting continuously, grant order is 0,1,2,3,0,...
- resp_ready asserted while resp_valid=0 is ignored.
- Reset asserted in any state aborts the transaction. No response is issued for the in-flight request.
- core_soft_rst is 0 at all times except the watchdog case.

Optional Feature:
SVM_WATCHDOG_EN
- Defined:
  - In WAIT, if the latency counter reaches TIMEOUT_CYCLES without core_output_valid, core_soft_rst=1 for one cycle.
  - State goes to RESP with resp_error=1, resp_decision=0, resp_prediction=0, resp_latency=TIMEOUT_CYCLES.
  - If core_output_valid arrives in the same cycle the limit is reached, the valid result wins: resp_error=0 and no soft reset.
- Undefined: WAIT lasts indefinitely. core_soft_rst and resp_error are tied 0. TIMEOUT_CYCLES is unused.

Test Plan:
Bench uses a behavioural core returning decision = sum of features, with fixed latency L=5 cycles after input_valid.
- Single request: req_valid=4'b0100, features all 0x0100 -> req_ready=4'b0100 for 1 cycle, core_input_valid next cycle, resp_id=2, resp_decision=0x1000, resp_latency=5, resp_error=0.
- Fairness: all four req_valid held high for 8 transactions, resp_ready=1 -> resp_id sequence 0,1,2,3,0,1,2,3. No req_ready while busy=1.
- Backpressure: resp_ready=0 for 10 cycles after resp_valid -> resp_* stable, req_ready=0 throughout. Releasing resp_ready returns busy=0 the following cycle.
- Spurious strobe: core_output_valid pulsed in IDLE and in RESP -> no resp_valid change, latched values unchanged.
- Reset mid-WAIT: assert rst 2 cycles after core_input_valid -> all outputs 0 immediately. Next request from requester 0 is served first.
- Watchdog (macro defined, TIMEOUT_CYCLES=20, core never responds) -> core_soft_rst one-cycle pulse, resp_error=1, resp_decision=0, resp_latency=20. Without the macro, busy stays 1 for 1000 cycles.
